// File: rtl/button_debouncer_if.sv
// Button bundle between raw board pins and the debounced level/strobe outputs.
// master drives the raw pins; slave is the conditioner that produces levels and strobes.
interface button_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;
    logic [WIDTH-1:0] btn_hold;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_hold
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_hold
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-flop sync, stability-count debounce, press/release/hold strobes.
// Latency DEBOUNCE_CYCLES+2 clocks from pin step to level/strobe; free-running, no backpressure.
module button_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter bit INVERT          = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    button_debouncer_if.slave btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] press_vec;
    logic [WIDTH-1:0] release_vec;
    logic [WIDTH-1:0] hold_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          s1_q, s1_d;
        logic          s2_q, s2_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          hold_q, hold_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic [1:0]    state_q, state_d;
        logic          accept;

        always_comb begin
            s1_d      = btn.btn_raw[i] ^ INVERT;
            s2_d      = s1_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            hold_d    = 1'b0;
            state_d   = state_q;

            // Any cycle of agreement restarts the count, so only a full stable run is accepted.
            accept  = (s2_q != level_q) && (cnt_q == CNT_LAST);
            level_d = accept ? s2_q : level_q;
            cnt_d   = ((s2_q == level_q) || accept) ? '0 : cnt_q + CW'(1);

            case (state_q)
                ST_RELEASED: begin
                    if (accept) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A release accepted on the expiry cycle suppresses the hold strobe.
                    if (accept) begin
                        state_d   = ST_RELEASED;
                        release_d = 1'b1;
                    end else if (hcnt_q == HCNT_LAST) begin
                        state_d = ST_HELD;
                        hold_d  = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (accept) begin
                        state_d   = ST_RELEASED;
                        release_d = 1'b1;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase

            if (!level_q || accept) begin
                hcnt_d = '0;
            end else if (hcnt_q != HCNT_MAX) begin
                hcnt_d = hcnt_q + HW'(1);
            end else begin
                hcnt_d = hcnt_q;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
                cnt_q     <= '0;
                hcnt_q    <= '0;
                state_q   <= ST_RELEASED;
            end else begin
                s1_q      <= s1_d;
                s2_q      <= s2_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                hold_q    <= hold_d;
                cnt_q     <= cnt_d;
                hcnt_q    <= hcnt_d;
                state_q   <= state_d;
            end
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign hold_vec[i]    = hold_q;
    end

    assign btn.btn_level   = level_vec;
    assign btn.btn_press   = press_vec;
    assign btn.btn_release = release_vec;
    assign btn.btn_hold    = hold_vec;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, INVERT=1.
module tb_button_debouncer;
    logic clk;
    logic reset_n;

    int total;
    int passed;
    int press_cnt [4];
    int release_cnt [4];
    int hold_cnt [4];

    button_debouncer_if #(.WIDTH(4)) bus ();

    button_debouncer #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .INVERT         (1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .btn    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            press_cnt[c]   = 0;
            release_cnt[c] = 0;
            hold_cnt[c]    = 0;
        end
    endtask

    // Advance one clock and sample 1 ns after the edge, tallying strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (bus.btn_press[c] === 1'b1)   press_cnt[c]++;
            if (bus.btn_release[c] === 1'b1) release_cnt[c]++;
            if (bus.btn_hold[c] === 1'b1)    hold_cnt[c]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        clear_counts();
        reset_n = 1'b0;
        bus.btn_raw = 4'hF;
        #1;
        check("rst_level", bus.btn_level, 4'h0);
        check("rst_strobes", {bus.btn_press, bus.btn_release, bus.btn_hold}, 12'h000);
        ticks(3);
        reset_n = 1'b1;

        // Idle released buttons after reset: nothing moves.
        ticks(50);
        check("idle_level", bus.btn_level, 4'h0);
        check("idle_press_cnt", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        check("idle_rel_hold_cnt", release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3]
                                   + hold_cnt[0] + hold_cnt[1] + hold_cnt[2] + hold_cnt[3], 0);

        // Clean press on channel 0: level and press appear at edge 6.
        clear_counts();
        bus.btn_raw = 4'hE;
        ticks(5);
        check("clean_e5_level", bus.btn_level, 4'h0);
        check("clean_e5_press", bus.btn_press, 4'h0);
        tick();
        check("clean_e6_level", bus.btn_level, 4'h1);
        check("clean_e6_press", bus.btn_press, 4'h1);
        tick();
        check("clean_e7_press", bus.btn_press, 4'h0);
        check("clean_e7_level", bus.btn_level, 4'h1);
        bus.btn_raw = 4'hF;
        ticks(20);
        check("clean_rel_cnt", release_cnt[0], 1);
        check("clean_hold_cnt", hold_cnt[0], 0);
        check("clean_press_cnt", press_cnt[0], 1);
        check("clean_level_end", bus.btn_level, 4'h0);

        // Bounce on channel 1: 2-cycle toggles for 20 cycles, then settle low.
        clear_counts();
        for (int p = 0; p < 5; p++) begin
            bus.btn_raw = 4'hD;
            ticks(2);
            bus.btn_raw = 4'hF;
            ticks(2);
        end
        check("bounce_no_press", press_cnt[1], 0);
        bus.btn_raw = 4'hD;
        ticks(5);
        check("bounce_s5_press", bus.btn_press, 4'h0);
        tick();
        check("bounce_s6_press", bus.btn_press, 4'h2);
        check("bounce_press_cnt", press_cnt[1], 1);
        check("bounce_rel_cnt", release_cnt[1], 0);
        bus.btn_raw = 4'hF;
        ticks(20);
        clear_counts();

        // Long hold on channel 2.
        bus.btn_raw = 4'hB;
        ticks(6);
        check("hold_press", bus.btn_press, 4'h4);
        ticks(9);
        check("hold_p9_hold", bus.btn_hold, 4'h0);
        tick();
        check("hold_p10_hold", bus.btn_hold, 4'h4);
        ticks(20);
        check("hold_single", hold_cnt[2], 1);
        check("hold_level", bus.btn_level, 4'h4);
        bus.btn_raw = 4'hF;
        ticks(5);
        check("hold_r5_rel", bus.btn_release, 4'h0);
        tick();
        check("hold_r6_rel", bus.btn_release, 4'h4);
        check("hold_r6_level", bus.btn_level, 4'h0);
        ticks(15);
        check("hold_rel_cnt", release_cnt[2], 1);
        check("hold_final_cnt", hold_cnt[2], 1);

        // Short press on channel 3: releases before hold expiry.
        clear_counts();
        bus.btn_raw = 4'h7;
        ticks(8);
        check("short_press_cnt", press_cnt[3], 1);
        bus.btn_raw = 4'hF;
        ticks(5);
        check("short_r5_rel", bus.btn_release, 4'h0);
        tick();
        check("short_r6_rel", bus.btn_release, 4'h8);
        ticks(15);
        check("short_hold_cnt", hold_cnt[3], 0);
        check("short_rel_cnt", release_cnt[3], 1);

        // Asynchronous reset clears a pressed channel without a clock edge.
        clear_counts();
        bus.btn_raw = 4'hE;
        ticks(6);
        check("arst_pre_level", bus.btn_level, 4'h1);
        reset_n = 1'b0;
        #1;
        check("arst_level", bus.btn_level, 4'h0);
        tick();
        reset_n = 1'b1;

        // Reset at cnt=2 discards the partial count: full 6-cycle latency again.
        ticks(4);
        check("mid_e4_level", bus.btn_level, 4'h0);
        reset_n = 1'b0;
        ticks(2);
        check("mid_rst_level", bus.btn_level, 4'h0);
        reset_n = 1'b1;
        clear_counts();
        ticks(5);
        check("mid_e5_press", press_cnt[0], 0);
        tick();
        check("mid_e6_press", bus.btn_press, 4'h1);
        check("mid_e6_level", bus.btn_level, 4'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Four-channel push-button conditioner placed directly upstream of the Nios II button PIO: raw board KEY pins enter here, and the debounced, active-high levels drive the PIO's `in_port`. Each channel synchronises its asynchronous pin, rejects contact bounce with a per-channel stability counter, and produces single-cycle press, release and long-hold strobes for fabric-side game logic. The PIO's edge capture therefore sees exactly one rising edge per physical press.

## Interface
- `WIDTH`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a new level (10 ms at 50 MHz). Must be at least 2.
- `HOLD_CYCLES`, 25000000: cycles a debounced press must persist before `btn_hold` fires (0.5 s). Must be at least 1.
- `INVERT`, 1: 1 means raw pins are active-low (pressed = 0); 0 means active-high.
- `clk`  in  1  system clock, 50 MHz nominal.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  WIDTH  raw button pins, asynchronous to `clk`.
- `btn_level`  out  WIDTH  debounced level, active-high (1 = pressed). Connects to PIO `in_port`.
- `btn_press`  out  WIDTH  one-cycle strobe on an accepted 0→1 transition of `btn_level`.
- `btn_release`  out  WIDTH  one-cycle strobe on an accepted 1→0 transition of `btn_level`.
- `btn_hold`  out  WIDTH  one-cycle strobe when a press has lasted `HOLD_CYCLES` cycles.

## Operation
- Channels are fully independent. No state is shared between channels.
- Normalise each input: `n = btn_raw[i] ^ INVERT`.
- Pass `n` through a 2-flop synchroniser `s1 → s2`. Both flops reset to 0 (released).
- Stability counter `cnt`:
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == btn_level[i]`, then `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
  - When `cnt == DEBOUNCE_CYCLES-1` and `s2 != btn_level[i]`: `btn_level[i] <= s2` and `cnt <= 0`.
  - Any single-cycle agreement between `s2` and `btn_level[i]` restarts the count from 0. Glitches shorter than `DEBOUNCE_CYCLES` are never propagated.
- Edge strobes:
  - `btn_press[i]` and `btn_release[i]` are registered.
  - Each is asserted in the same cycle that `btn_level[i]` first shows its new value, for exactly one cycle.
- Hold counter `hcnt`:
  - Width is `$clog2(HOLD_CYCLES+1)`.
  - Cleared while `btn_level[i] == 0`.
  - While `btn_level[i] == 1`, increments and saturates at `HOLD_CYCLES`.
  - `btn_hold[i]` pulses for one cycle on the cycle `hcnt` becomes `HOLD_CYCLES`.
  - It does not pulse again until after a release.
- Per-channel state machine:
  - RELEASED: on an accepted 1 → PRESSED, with `btn_press`.
  - PRESSED: on hold expiry → HELD, with `btn_hold`; on an accepted 0 → RELEASED, with `btn_release`.
  - HELD: on an accepted 0 → RELEASED, with `btn_release`.
- Release before hold expiry gives no `btn_hold`.
- There is no software-visible register. All outputs are free-running.

## Timing
- Reset (asynchronous, applies immediately): `btn_level`, `btn_press`, `btn_release`, `btn_hold`, `s1`, `s2`, `cnt` and `hcnt` are all 0; state is RELEASED.
  - With `INVERT=1` and buttons released, the inputs equal `btn_level`, so no strobe fires after reset.
  - If a button is held through reset, `btn_press` fires `DEBOUNCE_CYCLES+2` cycles after deassertion.
- Press latency, for a clean input step settling before clock edge 1:
  - `s2` updates at edge 2.
  - `btn_level` and `btn_press` update at edge `DEBOUNCE_CYCLES+2`.
  - Release latency is identical.
- `btn_hold` asserts `HOLD_CYCLES` cycles after `btn_press`.
- Overlapping strobes:
  - `btn_press` and `btn_release` are never asserted together on one channel.
  - `btn_hold` never coincides with `btn_press`.
  - If release is accepted in the same cycle `hcnt` would reach `HOLD_CYCLES`, release wins and `btn_hold` is not asserted.
- Reset asserted mid-count discards the partial count. The channel restarts from RELEASED.
- Counters never wrap: `cnt` is bounded by the accept rule, and `hcnt` saturates.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=10`, `INVERT=1`.
- Reset with `btn_raw=4'hF` held for 50 cycles → all outputs stay 0 and no strobes fire.
- Clean press: `btn_raw[0]` goes 1→0 before edge 1 → `btn_level[0]` and `btn_press[0]` rise at edge 6; `btn_press[0]` is low at edge 7; other channels are unaffected.
- Bounce: `btn_raw[1]` toggles every 2 cycles for 20 cycles, then settles at 0 → exactly one `btn_press[1]`, 6 cycles after the settle; no `btn_release[1]`.
- Hold: keep `btn_raw[2]` at 0 for 30 cycles after acceptance, then release → one `btn_hold[2]` 10 cycles after `btn_press[2]`; one `btn_release[2]` 6 cycles after the pin returns to 1; no second hold.
- Short press: `btn_raw[3]` low for 8 cycles → `btn_press[3]`, then `btn_release[3]`; `btn_hold[3]` never asserts.
- Reset mid-count: assert `reset_n=0` when `cnt=2` during a press → after deassertion the full 6-cycle latency is re-observed before `btn_press`.
